lpif_txrx_x4_quarter_gearbox_ctrl: RTL

Quarter-rate gearbox sequencer between a full-rate single-beat LPIF stream and the 308-bit asymmetric FIFO word.
- TX: packs 4 consecutive 77-bit beats (2 in gen2 mode) into one FIFO word, slot k at bits [k*77 +: 77], and schedules the push against FIFO full.
- RX: pops FIFO words and replays their slots as single beats under a valid/ready handshake.
- Slot beat layout, LSB first: state 4b, protid 2b, data 64b, dvalid 1b, crc 4b, crc_valid 1b, valid 1b.

---
 rtl/lpif_txrx_x4_quarter_gearbox_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lpif_txrx_x4_quarter_gearbox_ctrl.sv
// lpif_txrx_x4_quarter_gearbox_ctrl: quarter-rate gearbox packing LPIF beats into 308-bit FIFO words and replaying them.
// Optional partial-word flush after idle timeout is enabled by defining LPIF_QCTRL_FLUSH_EN.
module lpif_txrx_x4_quarter_gearbox_ctrl #(
    parameter int BEAT_W = 77,
    parameter int NBEAT  = 4
`ifdef LPIF_QCTRL_FLUSH_EN
    ,
    parameter int FLUSH_TIMEOUT = 16
`endif
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr,
    input  logic                      m_gen2_mode,
    input  logic [BEAT_W-1:0]         tx_beat_data,
    input  logic                      tx_beat_vld,
    output logic                      tx_beat_rdy,
    output logic [BEAT_W*NBEAT-1:0]   txfifo_downstream_data,
    output logic                      txfifo_push,
    input  logic                      txfifo_full,
    input  logic [BEAT_W*NBEAT-1:0]   rxfifo_upstream_data,
    input  logic                      rxfifo_empty,
    output logic                      rxfifo_pop,
    output logic [BEAT_W-1:0]         rx_beat_data,
    output logic                      rx_beat_vld,
    input  logic                      rx_beat_rdy,
    output logic [1:0]                tx_slot,
    output logic [1:0]                rx_slot
);
    localparam int WORD_W = BEAT_W * NBEAT;

    typedef enum logic [1:0] {RX_IDLE, RX_LOAD, RX_DRAIN} rx_state_e;

    logic              mode_q, mode_d;
    logic [1:0]        last_slot;
    logic [1:0]        tx_slot_q, tx_slot_d;
    logic [WORD_W-1:0] asm_q, asm_d, asm_w;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              push_q, push_d;
    logic              tx_last, push_done, accept, flush;
    rx_state_e         rx_state_q, rx_state_d;
    logic [1:0]        rx_slot_q, rx_slot_d;
    logic [WORD_W-1:0] replay_q, replay_d;
    logic              pop_c, vld_c;

    assign last_slot = mode_q ? 2'd1 : 2'(NBEAT - 1);
    assign tx_last   = tx_slot_q == last_slot;
    assign push_done = push_q && !txfifo_full;
    // The last slot can only be taken once the holding register is free or frees this cycle.
    assign tx_beat_rdy = !rst_wr && (!tx_last || !push_q || !txfifo_full);
    assign accept    = tx_beat_vld && tx_beat_rdy;

    assign txfifo_downstream_data = hold_q;
    assign txfifo_push            = push_q;
    assign tx_slot                = tx_slot_q;
    assign rx_slot                = rx_slot_q;
    assign rx_beat_data           = replay_q[rx_slot_q*BEAT_W +: BEAT_W];
    assign rxfifo_pop             = pop_c && !rst_wr;
    assign rx_beat_vld            = vld_c && !rst_wr;

    // Mode may only change when neither direction has a word in flight.
    assign mode_d = (tx_slot_q == 2'd0 && !push_q && rx_state_q == RX_IDLE) ? m_gen2_mode : mode_q;

`ifdef LPIF_QCTRL_FLUSH_EN
    localparam int CNT_W = $clog2(FLUSH_TIMEOUT + 1);
    logic [CNT_W-1:0] idle_q, idle_d;
    assign flush  = tx_slot_q != 2'd0 && idle_q == CNT_W'(FLUSH_TIMEOUT) && !push_done == !push_q && !accept
                    || tx_slot_q != 2'd0 && idle_q == CNT_W'(FLUSH_TIMEOUT) && push_done && !accept;
    assign idle_d = (tx_slot_q == 2'd0 || accept || flush) ? '0 :
                    (idle_q == CNT_W'(FLUSH_TIMEOUT) ? idle_q : idle_q + 1'b1);
    // Idle counter for a partially assembled word; saturates while waiting for the holding register.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    assign flush = 1'b0;
`endif

    // TX assembly, last-slot hand-off to the holding register and push scheduling.
    always_comb begin
        asm_w = asm_q;
        asm_w[tx_slot_q*BEAT_W +: BEAT_W] = tx_beat_data;
        tx_slot_d = tx_slot_q;
        asm_d     = asm_q;
        hold_d    = push_done ? '0 : hold_q;
        push_d    = push_q && txfifo_full;
        if (accept) begin
            tx_slot_d = tx_last ? 2'd0 : tx_slot_q + 2'd1;
            asm_d     = tx_last ? '0 : asm_w;
            if (tx_last) begin
                hold_d = asm_w;
                push_d = 1'b1;
            end
        end else if (flush) begin
            tx_slot_d = 2'd0;
            asm_d     = '0;
            hold_d    = asm_q;
            push_d    = 1'b1;
        end
    end

    // RX replay FSM: pop, capture one cycle later, then present slots one by one.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_slot_d  = rx_slot_q;
        replay_d   = replay_q;
        pop_c      = 1'b0;
        vld_c      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxfifo_empty) begin
                    pop_c      = 1'b1;
                    rx_state_d = RX_LOAD;
                end
            end
            RX_LOAD: begin
                replay_d   = rxfifo_upstream_data;
                rx_slot_d  = 2'd0;
                rx_state_d = RX_DRAIN;
            end
            RX_DRAIN: begin
                vld_c = 1'b1;
                if (rx_beat_rdy) begin
                    if (rx_slot_q == last_slot) begin
                        rx_slot_d  = 2'd0;
                        pop_c      = !rxfifo_empty;
                        rx_state_d = rxfifo_empty ? RX_IDLE : RX_LOAD;
                    end else begin
                        rx_slot_d = rx_slot_q + 2'd1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // State registers for both directions and the shared mode latch.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            mode_q     <= 1'b0;
            tx_slot_q  <= 2'd0;
            asm_q      <= '0;
            hold_q     <= '0;
            push_q     <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_slot_q  <= 2'd0;
            replay_q   <= '0;
        end else begin
            mode_q     <= mode_d;
            tx_slot_q  <= tx_slot_d;
            asm_q      <= asm_d;
            hold_q     <= hold_d;
            push_q     <= push_d;
            rx_state_q <= rx_state_d;
            rx_slot_q  <= rx_slot_d;
            replay_q   <= replay_d;
        end
    end
endmodule
